// File: rtl/aes_round_ctrl_if.sv
// Handshake and datapath bundle between the AES round sequencer and its
// environment: start/din, key schedule handshake, round datapath, output.
interface aes_round_ctrl_if;
   logic         start;
   logic [127:0] din;
   logic         ready;
   logic         key_req;
   logic [3:0]   key_idx;
   logic         key_vld;
   logic [127:0] round_key;
   logic [127:0] rnd_in;
   logic         rnd_last;
   logic [127:0] rnd_out;
   logic [127:0] dout;
   logic         dout_vld;
   logic         dout_rdy;
   logic [3:0]   round;

   modport slave (
      input  start, din, key_vld, round_key, rnd_out, dout_rdy,
      output ready, key_req, key_idx, rnd_in, rnd_last, dout, dout_vld, round
   );

   modport master (
      output start, din, key_vld, round_key, rnd_out, dout_rdy,
      input  ready, key_req, key_idx, rnd_in, rnd_last, dout, dout_vld, round
   );
endinterface

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: owns the cipher state, fetches one round key per
// round and steps the state through AddRoundKey plus NR external rounds.
module aes_round_ctrl #(
   parameter int NR = 10
) (
   input  logic           clk,
   input  logic           rst_n,
   aes_round_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, INIT, ROUND, DONE} fsm_e;

   localparam logic [3:0] LAST = 4'(NR);

   fsm_e         fsm_q, fsm_d;
   logic [127:0] st_q, st_d;
   logic [3:0]   round_q, round_d;
   logic         ready_q, key_req_q, rnd_last_q, dout_vld_q;
   logic [3:0]   key_idx_q;

   // key_vld only matters in INIT/ROUND, so stray strobes elsewhere fall through.
   always_comb begin
      fsm_d   = fsm_q;
      st_d    = st_q;
      round_d = round_q;
      case (fsm_q)
         IDLE: begin
            if (bus.start) begin
               st_d    = bus.din;
               round_d = '0;
               fsm_d   = INIT;
            end
         end
         INIT: begin
            if (bus.key_vld) begin
               st_d    = st_q ^ bus.round_key;
               round_d = 4'd1;
               fsm_d   = ROUND;
            end
         end
         ROUND: begin
            if (bus.key_vld) begin
               st_d = bus.rnd_out ^ bus.round_key;
               if (round_q == LAST) fsm_d = DONE;
               else                 round_d = round_q + 4'd1;
            end
         end
         DONE: begin
            if (bus.dout_rdy) begin
               fsm_d   = IDLE;
               round_d = '0;
            end
         end
         default: fsm_d = IDLE;
      endcase
   end

   // Status outputs are registered from the next-state values so they line
   // up with fsm_q/round_q without any combinational decode on the ports.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q      <= IDLE;
         st_q       <= '0;
         round_q    <= '0;
         ready_q    <= 1'b1;
         key_req_q  <= 1'b0;
         key_idx_q  <= '0;
         rnd_last_q <= 1'b0;
         dout_vld_q <= 1'b0;
      end else begin
         fsm_q      <= fsm_d;
         st_q       <= st_d;
         round_q    <= round_d;
         ready_q    <= (fsm_d == IDLE);
         key_req_q  <= (fsm_d == INIT) || (fsm_d == ROUND);
         key_idx_q  <= ((fsm_d == INIT) || (fsm_d == ROUND)) ? round_d : 4'd0;
         rnd_last_q <= (fsm_d == ROUND) && (round_d == LAST);
         dout_vld_q <= (fsm_d == DONE);
      end
   end

   assign bus.ready    = ready_q;
   assign bus.key_req  = key_req_q;
   assign bus.key_idx  = key_idx_q;
   assign bus.rnd_in   = st_q;
   assign bus.rnd_last = rnd_last_q;
   assign bus.dout     = st_q;
   assign bus.dout_vld = dout_vld_q;
   assign bus.round    = round_q;

endmodule
